// File: rtl/life_game_sequencer_pkg.sv
// Shared definitions for the Game-of-Life sequencer: world defaults, the
// frame-swap address, FSM state encodings and the neighbour offset table.
package life_game_sequencer_pkg;

    localparam int unsigned CELL_COUNT_X_DEFAULT = 64;
    localparam int unsigned CELL_COUNT_Y_DEFAULT = 48;

    // Writing here selects which frame the cell store reads from (data bit 0).
    localparam logic [11:0] SWAP_ADDRESS = 12'hFFF;

    // Neighbour reads per cell run k = 0 (self) .. 8.
    localparam logic [3:0] LAST_NEIGHBOR = 4'd8;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StRead  = 3'd1,
        StDrain = 3'd2,
        StWrite = 3'd3,
        StSwap  = 3'd4
    } state_e;

    // Offsets are two's complement in two bits: -1, 0 or +1.
    localparam logic [1:0] OFF_MINUS = 2'b11;
    localparam logic [1:0] OFF_ZERO  = 2'b00;
    localparam logic [1:0] OFF_PLUS  = 2'b01;

    typedef struct packed {
        logic [1:0] dy;
        logic [1:0] dx;
    } offset_t;

    // Neighbour offset table, indexed by read number k.
    function automatic offset_t neighbor_offset(input logic [3:0] k);
        offset_t o;
        case (k)
            4'd1:    o = {OFF_MINUS, OFF_MINUS};
            4'd2:    o = {OFF_MINUS, OFF_ZERO};
            4'd3:    o = {OFF_MINUS, OFF_PLUS};
            4'd4:    o = {OFF_ZERO,  OFF_MINUS};
            4'd5:    o = {OFF_ZERO,  OFF_PLUS};
            4'd6:    o = {OFF_PLUS,  OFF_MINUS};
            4'd7:    o = {OFF_PLUS,  OFF_ZERO};
            4'd8:    o = {OFF_PLUS,  OFF_PLUS};
            default: o = {OFF_ZERO,  OFF_ZERO};
        endcase
        return o;
    endfunction

endpackage

// File: rtl/life_game_neighbor_address.sv
// Maps a cell (y, x) and neighbour number k to a toroidally wrapped
// cell-store address {y[5:0], x[5:0]}. Purely combinational.
module life_game_neighbor_address
    import life_game_sequencer_pkg::*;
#(
    parameter int unsigned CELL_COUNT_Y = CELL_COUNT_Y_DEFAULT
) (
    input  logic [5:0]  y,
    input  logic [5:0]  x,
    input  logic [3:0]  k,
    output logic [11:0] address
);

    localparam logic [5:0] LAST_ROW = 6'(CELL_COUNT_Y - 1);

    offset_t    offset;
    logic [5:0] ny;
    logic [5:0] nx;

    // Rows wrap explicitly at the world height; columns wrap naturally in 6 bits.
    always_comb begin
        offset = neighbor_offset(k);
        ny     = y;
        if (offset.dy == OFF_MINUS) begin
            ny = (y == 6'd0) ? LAST_ROW : y - 6'd1;
        end else if (offset.dy == OFF_PLUS) begin
            ny = (y == LAST_ROW) ? 6'd0 : y + 6'd1;
        end
        nx      = x + {{4{offset.dx[1]}}, offset.dx};
        address = {ny, nx};
    end

endmodule

// File: rtl/life_game_sequencer.sv
// Game-of-Life generation sequencer. Scans every cell of the current frame,
// reads its eight neighbours from a one-cycle-latency cell store, writes the
// next state into the other frame and finally flips the frame index. The CPU
// owns the cell port whenever the engine is idle.
module life_game_sequencer
    import life_game_sequencer_pkg::*;
#(
    parameter int unsigned CELL_COUNT_X = CELL_COUNT_X_DEFAULT,
    parameter int unsigned CELL_COUNT_Y = CELL_COUNT_Y_DEFAULT,
    parameter int unsigned AUTO_PERIOD  = 25000000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        step,
    input  logic        run,
    output logic        busy,
    output logic        done,
    output logic [15:0] generation,
    input  logic        cpu_write,
    input  logic [11:0] cpu_address,
    input  logic [31:0] cpu_data_in,
    output logic [31:0] cpu_data_out,
    output logic        cpu_grant,
    output logic        cell_write,
    output logic [11:0] cell_address,
    output logic [31:0] cell_data_in,
    input  logic [31:0] cell_data_out
);

    localparam int unsigned AUTO_WIDTH = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
    localparam logic [AUTO_WIDTH-1:0] AUTO_LAST = AUTO_WIDTH'(AUTO_PERIOD - 1);
    localparam logic [5:0] LAST_X = 6'(CELL_COUNT_X - 1);
    localparam logic [5:0] LAST_Y = 6'(CELL_COUNT_Y - 1);

    state_e                state_q, state_d;
    logic [3:0]            k_q;
    logic [5:0]            x_q;
    logic [5:0]            y_q;
    logic                  self_q;
    logic [3:0]            count_q;
    logic                  shadow_q;
    logic [15:0]           generation_q;
    logic [AUTO_WIDTH-1:0] auto_q;
    logic                  done_q;

    logic                  start;
    logic                  last_cell;
    logic                  next_alive;
    logic                  swap_forwarded;
    logic [11:0]           neighbor_address;
    logic                  engine_write;
    logic [11:0]           engine_address;
    logic [31:0]           engine_data;

    assign start      = (state_q == StIdle) && (step || (run && (auto_q == AUTO_LAST)));
    assign last_cell  = (x_q == LAST_X) && (y_q == LAST_Y);
    assign next_alive = (count_q == 4'd3) || (self_q && (count_q == 4'd2));

    // A CPU write reaches the store only while granted.
    assign swap_forwarded = cpu_grant && cpu_write && (cpu_address == SWAP_ADDRESS);

    life_game_neighbor_address #(
        .CELL_COUNT_Y(CELL_COUNT_Y)
    ) u_neighbor_address (
        .y      (y_q),
        .x      (x_q),
        .k      (k_q),
        .address(neighbor_address)
    );

    // FSM state register.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and engine-side cell-port drive.
    always_comb begin
        state_d        = state_q;
        engine_write   = 1'b0;
        engine_address = neighbor_address;
        engine_data    = 32'd0;
        case (state_q)
            StIdle: begin
                if (start) state_d = StRead;
            end
            StRead: begin
                if (k_q == LAST_NEIGHBOR) state_d = StDrain;
            end
            StDrain: begin
                state_d = StWrite;
            end
            StWrite: begin
                engine_write   = 1'b1;
                engine_address = {y_q, x_q};
                engine_data    = {31'd0, next_alive};
                state_d        = last_cell ? StSwap : StRead;
            end
            StSwap: begin
                engine_write   = 1'b1;
                engine_address = SWAP_ADDRESS;
                engine_data    = {31'd0, ~shadow_q};
                state_d        = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Cell scan position, neighbour index and neighbourhood accumulation.
    // Read data lags its address by one cycle, so READ k samples read k-1
    // and DRAIN samples the last neighbour.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            k_q     <= 4'd0;
            x_q     <= 6'd0;
            y_q     <= 6'd0;
            self_q  <= 1'b0;
            count_q <= 4'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        k_q     <= 4'd0;
                        x_q     <= 6'd0;
                        y_q     <= 6'd0;
                        count_q <= 4'd0;
                    end
                end
                StRead: begin
                    k_q <= (k_q == LAST_NEIGHBOR) ? 4'd0 : k_q + 4'd1;
                    if (k_q == 4'd1) begin
                        self_q <= cell_data_out[0];
                    end else if (k_q != 4'd0) begin
                        count_q <= count_q + {3'd0, cell_data_out[0]};
                    end
                end
                StDrain: begin
                    count_q <= count_q + {3'd0, cell_data_out[0]};
                end
                StWrite: begin
                    count_q <= 4'd0;
                    if (!last_cell) begin
                        if (x_q == LAST_X) begin
                            x_q <= 6'd0;
                            y_q <= y_q + 6'd1;
                        end else begin
                            x_q <= x_q + 6'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Frame-index shadow, generation counter and completion pulse.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            shadow_q     <= 1'b0;
            generation_q <= 16'd0;
            done_q       <= 1'b0;
        end else begin
            done_q <= (state_q == StSwap);
            if (state_q == StSwap) begin
                shadow_q     <= ~shadow_q;
                generation_q <= generation_q + 16'd1;
            end else if (swap_forwarded) begin
                shadow_q <= cpu_data_in[0];
            end
        end
    end

    // Auto-run counter: counts idle cycles while run is set, frozen while busy.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            auto_q <= '0;
        end else if (!run || start) begin
            auto_q <= '0;
        end else if (state_q == StIdle) begin
            auto_q <= auto_q + AUTO_WIDTH'(1);
        end
    end

    assign cpu_grant    = (state_q == StIdle);
    assign busy         = ~cpu_grant;
    assign done         = done_q;
    assign generation   = generation_q;
    assign cpu_data_out = cell_data_out;
    assign cell_write   = cpu_grant ? cpu_write   : engine_write;
    assign cell_address = cpu_grant ? cpu_address : engine_address;
    assign cell_data_in = cpu_grant ? cpu_data_in : engine_data;

endmodule

// File: tb/tb_life_game_sequencer.sv
// Bench for life_game_sequencer on a reduced 64x8 world: a two-frame cell
// store with one-cycle read latency, and a plain-arithmetic Life model.
module tb_life_game_sequencer;

    localparam int CX      = 64;
    localparam int CY      = 8;
    localparam int AP      = 60;
    localparam int GEN_CYC = CY * CX * 11 + 1;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        step = 1'b0;
    logic        run = 1'b0;
    logic        cpu_write = 1'b0;
    logic [11:0] cpu_address = 12'd0;
    logic [31:0] cpu_data_in = 32'd0;
    logic        busy;
    logic        done;
    logic [15:0] generation;
    logic [31:0] cpu_data_out;
    logic        cpu_grant;
    logic        cell_write;
    logic [11:0] cell_address;
    logic [31:0] cell_data_in;
    logic [31:0] cell_data_out;

    always #5 clock = ~clock;

    life_game_sequencer #(
        .CELL_COUNT_X(CX),
        .CELL_COUNT_Y(CY),
        .AUTO_PERIOD (AP)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .step         (step),
        .run          (run),
        .busy         (busy),
        .done         (done),
        .generation   (generation),
        .cpu_write    (cpu_write),
        .cpu_address  (cpu_address),
        .cpu_data_in  (cpu_data_in),
        .cpu_data_out (cpu_data_out),
        .cpu_grant    (cpu_grant),
        .cell_write   (cell_write),
        .cell_address (cell_address),
        .cell_data_in (cell_data_in),
        .cell_data_out(cell_data_out)
    );

    // Cell store: reads from the current frame, writes into the other one.
    bit          store [2][4096];
    bit          fidx = 1'b0;
    logic [31:0] rdata = 32'd0;
    assign cell_data_out = rdata;

    always @(posedge clock) begin
        rdata <= {31'd0, store[fidx][cell_address]};
        if (cell_write) begin
            if (cell_address == 12'hFFF) fidx <= cell_data_in[0];
            else store[~fidx][cell_address] <= cell_data_in[0];
        end
    end

    // Event tallies taken on the falling edge.
    int          busy_cyc = 0;
    int          done_cnt = 0;
    int          swap_cnt = 0;
    logic [31:0] last_swap = 32'd0;

    always @(negedge clock) begin
        if (busy === 1'b1) busy_cyc++;
        if (done === 1'b1) done_cnt++;
        if (cell_write === 1'b1 && cell_address === 12'hFFF && cpu_grant === 1'b0) begin
            swap_cnt++;
            last_swap = cell_data_in;
        end
    end

    int  total = 0;
    int  bad = 0;
    bit  world_m [CY][CX];
    bit  next_m  [CY][CX];
    bit  shadow_m = 1'b0;
    int  gen_m = 0;
    int  b0, d0, s0;
    bit  f0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference Life rule with toroidal wrap by plain modulo arithmetic.
    function automatic void life_step();
        for (int y = 0; y < CY; y++) begin
            for (int x = 0; x < CX; x++) begin
                int n = 0;
                for (int dy = -1; dy <= 1; dy++) begin
                    for (int dx = -1; dx <= 1; dx++) begin
                        if (dy != 0 || dx != 0) n += int'(world_m[(y + dy + CY) % CY][(x + dx + CX) % CX]);
                    end
                end
                next_m[y][x] = (n == 3) || (world_m[y][x] && n == 2);
            end
        end
    endfunction

    function automatic void clear_world();
        for (int y = 0; y < CY; y++)
            for (int x = 0; x < CX; x++) world_m[y][x] = 1'b0;
    endfunction

    function automatic void random_world();
        for (int y = 0; y < CY; y++)
            for (int x = 0; x < CX; x++) world_m[y][x] = ($urandom_range(0, 99) < 35);
    endfunction

    function automatic int frame_mismatch(input bit f);
        int m = 0;
        for (int y = 0; y < CY; y++)
            for (int x = 0; x < CX; x++)
                if (store[f][y * 64 + x] != next_m[y][x]) m++;
        return m;
    endfunction

    function automatic int frame_live(input bit f);
        int n = 0;
        for (int y = 0; y < CY; y++)
            for (int x = 0; x < CX; x++) n += int'(store[f][y * 64 + x]);
        return n;
    endfunction

    task automatic cpu_wr(input logic [11:0] a, input bit d);
        cpu_write   = 1'b1;
        cpu_address = a;
        cpu_data_in = {31'd0, d};
        tick();
        cpu_write = 1'b0;
        if (a == 12'hFFF) shadow_m = d;
    endtask

    // Fill frame tgt with world_m through the CPU port, then select it.
    task automatic load_world(input bit tgt);
        cpu_wr(12'hFFF, ~tgt);
        for (int y = 0; y < CY; y++)
            for (int x = 0; x < CX; x++) cpu_wr(12'(y * 64 + x), world_m[y][x]);
        cpu_wr(12'hFFF, tgt);
    endtask

    task automatic snap();
        b0 = busy_cyc;
        d0 = done_cnt;
        s0 = swap_cnt;
        f0 = fidx;
        life_step();
    endtask

    task automatic step_start(input string tag);
        snap();
        step = 1'b1;
        tick();
        step = 1'b0;
        check({tag, " busy after step"}, 32'(busy), 32'd1);
    endtask

    task automatic wait_done(input string tag);
        bit found = 1'b0;
        for (int i = 0; i < GEN_CYC + 20 && !found; i++) begin
            tick();
            if (done === 1'b1) found = 1'b1;
        end
        check({tag, " done seen"}, 32'(found), 32'd1);
        tick();
    endtask

    task automatic end_checks(input string tag);
        gen_m++;
        check({tag, " busy cycles"}, 32'(busy_cyc - b0), 32'(GEN_CYC));
        check({tag, " done pulses"}, 32'(done_cnt - d0), 32'd1);
        check({tag, " swap writes"}, 32'(swap_cnt - s0), 32'd1);
        check({tag, " swap data"}, last_swap, {31'd0, ~shadow_m});
        check({tag, " generation"}, 32'(generation), 32'(gen_m[15:0]));
        check({tag, " next frame"}, 32'(frame_mismatch(~f0)), 32'd0);
        check({tag, " idle after"}, 32'(busy), 32'd0);
        shadow_m = ~shadow_m;
        world_m  = next_m;
    endtask

    initial begin
        int gap;
        int sc;

        // Reset state.
        repeat (3) tick();
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset generation", 32'(generation), 32'd0);
        check("reset grant", 32'(cpu_grant), 32'd1);
        reset_n = 1'b1;
        tick();

        // Blinker, with CPU poke and a second step while busy.
        clear_world();
        world_m[4][9]  = 1'b1;
        world_m[4][10] = 1'b1;
        world_m[4][11] = 1'b1;
        load_world(1'b0);
        cpu_write   = 1'b1;
        cpu_address = 12'd5;
        cpu_data_in = 32'd1;
        #1;
        check("idle grant", 32'(cpu_grant), 32'd1);
        check("idle pass write", 32'(cell_write), 32'd1);
        check("idle pass address", 32'(cell_address), 32'd5);
        check("idle pass data", cell_data_in, 32'd1);
        check("read pass", cpu_data_out, rdata);
        tick();
        cpu_write = 1'b0;
        step_start("blinker");
        tick();
        cpu_write   = 1'b1;
        cpu_address = 12'd5;
        cpu_data_in = 32'd1;
        #1;
        check("busy grant", 32'(cpu_grant), 32'd0);
        check("busy cpu dropped", 32'(cell_write), 32'd0);
        check("busy cpu address", 32'(cell_address == 12'd5), 32'd0);
        tick();
        cpu_write = 1'b0;
        repeat (500) tick();
        step = 1'b1;
        tick();
        step = 1'b0;
        wait_done("blinker");
        end_checks("blinker");
        check("blinker top", 32'(store[fidx][3 * 64 + 10]), 32'd1);
        check("blinker mid", 32'(store[fidx][4 * 64 + 10]), 32'd1);
        check("blinker bottom", 32'(store[fidx][5 * 64 + 10]), 32'd1);
        check("blinker live", 32'(frame_live(fidx)), 32'd3);

        // Wrap-around blinker across x=63/0 and y=0/last row.
        clear_world();
        world_m[0][63] = 1'b1;
        world_m[0][0]  = 1'b1;
        world_m[0][1]  = 1'b1;
        load_world(1'b1);
        step_start("wrap");
        wait_done("wrap");
        end_checks("wrap");
        check("wrap top", 32'(store[fidx][(CY - 1) * 64]), 32'd1);
        check("wrap mid", 32'(store[fidx][0]), 32'd1);
        check("wrap bottom", 32'(store[fidx][64]), 32'd1);
        check("wrap live", 32'(frame_live(fidx)), 32'd3);

        // Random world.
        random_world();
        load_world(1'b0);
        step_start("random");
        wait_done("random");
        end_checks("random");

        // Auto-run from idle.
        snap();
        run = 1'b1;
        gap = 0;
        while (busy !== 1'b1 && gap < AP + 20) begin
            tick();
            gap++;
        end
        check("auto gap", 32'(gap), 32'(AP));
        wait_done("auto1");
        end_checks("auto1");

        // Step coinciding with the period hit starts one generation.
        repeat (AP - 2) tick();
        check("auto wait idle", 32'(busy), 32'd0);
        snap();
        step = 1'b1;
        tick();
        step = 1'b0;
        run  = 1'b0;
        check("auto+step busy", 32'(busy), 32'd1);
        wait_done("auto2");
        end_checks("auto2");
        repeat (2 * AP) tick();
        check("run off idle", 32'(busy), 32'd0);
        check("run off generation", 32'(generation), 32'(gen_m[15:0]));

        // Reset in the middle of a generation.
        random_world();
        load_world(1'b1);
        step_start("abort");
        repeat (100 * 11) tick();
        sc = swap_cnt;
        reset_n = 1'b0;
        tick();
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort generation", 32'(generation), 32'd0);
        check("abort grant", 32'(cpu_grant), 32'd1);
        reset_n = 1'b1;
        repeat (5) tick();
        check("abort no swap", 32'(swap_cnt - sc), 32'd0);
        gen_m    = 0;
        shadow_m = 1'b0;
        step_start("post reset");
        wait_done("post reset");
        end_checks("post reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
